sprite_collision_probe: RTL



---
 rtl/sprite_pkg.sv | 27 ++
 rtl/probe_addr_calc.sv | 49 ++++
 rtl/sprite_collision_probe.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, key codes and enums for the sprite collision probe.
package sprite_pkg;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_UP    = 8'h1A;

    localparam int unsigned SCREEN_W    = 640;
    localparam int unsigned SCREEN_H    = 480;
    localparam int unsigned MAP_W_TILES = 80;

    typedef enum logic [2:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN} dir_e;

    typedef enum logic [2:0] {IDLE, LATCH, ISSUE, WAIT, CHECK, DONE} state_e;

    function automatic dir_e decode_key(input logic [7:0] key);
        case (key)
            KEY_LEFT:  return DIR_LEFT;
            KEY_RIGHT: return DIR_RIGHT;
            KEY_DOWN:  return DIR_DOWN;
            KEY_UP:    return DIR_UP;
            default:   return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/probe_addr_calc.sv
// Combinational probe point: pixel coordinates, screen-bounds test and wall-map tile address.
module probe_addr_calc
    import sprite_pkg::*;
#(
    parameter int unsigned TILE_SHIFT = 3,
    parameter int unsigned STEP       = 2
) (
    input  dir_e               dir,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic [9:0]         s,
    input  logic signed [11:0] o,
    output logic signed [11:0] px,
    output logic signed [11:0] py,
    output logic               out_of_bounds,
    output logic [12:0]        addr
);

    localparam logic signed [11:0] STEP_S = 12'(STEP);
    localparam logic signed [11:0] W_S    = 12'(SCREEN_W);
    localparam logic signed [11:0] H_S    = 12'(SCREEN_H);

    logic signed [11:0] xs, ys, ss;
    logic [12:0] tx, ty;

    assign xs = signed'({2'b00, x});
    assign ys = signed'({2'b00, y});
    assign ss = signed'({2'b00, s});

    always_comb begin
        px = xs;
        py = ys;
        case (dir)
            DIR_LEFT:  begin px = xs - ss - STEP_S; py = ys + o; end
            DIR_RIGHT: begin px = xs + ss + STEP_S; py = ys + o; end
            DIR_UP:    begin px = xs + o; py = ys - ss - STEP_S; end
            DIR_DOWN:  begin px = xs + o; py = ys + ss + STEP_S; end
            default:   begin px = xs; py = ys; end
        endcase
    end

    assign out_of_bounds = (px < 0) || (py < 0) || (px >= W_S) || (py >= H_S);

    assign tx = {1'b0, px} >> TILE_SHIFT;
    assign ty = {1'b0, py} >> TILE_SHIFT;
    // row * 80 as (row << 6) + (row << 4); only meaningful when in bounds
    assign addr = (ty << 6) + (ty << 4) + tx;

endmodule

// File: rtl/sprite_collision_probe.sv
// Scans the sprite's leading edge against the wall-tile map once per frame tick
// and reports whether the next step in the key direction would hit a wall.
module sprite_collision_probe
    import sprite_pkg::*;
#(
    parameter int unsigned TILE_SHIFT = 3,
    parameter int unsigned STEP       = 2,
    parameter int unsigned READ_LAT   = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic [9:0]  spriteX,
    input  logic [9:0]  spriteY,
    input  logic [9:0]  spriteS,
    output logic [12:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_data,
    output logic        collision,
    output logic        busy,
    output logic        scan_done,
    output logic        overrun
);

    localparam logic signed [11:0] TILE      = 12'(1 << TILE_SHIFT);
    localparam logic [7:0]         WAIT_LAST = 8'(READ_LAT - 1);

    state_e             state;
    dir_e               dir_q;
    logic [9:0]         x_q, y_q, s_q;
    logic signed [11:0] o_q;
    logic               last_q;
    logic               result_q;
    logic [7:0]         wait_cnt;
    logic [12:0]        addr_q;
    logic [2:0]         frame_sync;
    logic               frame_rise;

    logic signed [11:0] probe_px, probe_py;
    logic               probe_oob;
    logic [12:0]        probe_addr;
    logic               unused_probe_xy;

    probe_addr_calc #(
        .TILE_SHIFT (TILE_SHIFT),
        .STEP       (STEP)
    ) u_calc (
        .dir           (dir_q),
        .x             (x_q),
        .y             (y_q),
        .s             (s_q),
        .o             (o_q),
        .px            (probe_px),
        .py            (probe_py),
        .out_of_bounds (probe_oob),
        .addr          (probe_addr)
    );

    assign unused_probe_xy = ^{probe_px, probe_py};

    // Two sync flops plus one history flop for edge detection
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_sync <= 3'b000;
        end else begin
            frame_sync <= {frame_sync[1:0], frame_clk};
        end
    end

    assign frame_rise = frame_sync[1] & ~frame_sync[2];

    // The read strobe must coincide with the address decision made in ISSUE
    assign mem_rd   = (state == ISSUE) && !probe_oob;
    assign mem_addr = (state == ISSUE) ? probe_addr : addr_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            dir_q     <= DIR_NONE;
            x_q       <= '0;
            y_q       <= '0;
            s_q       <= '0;
            o_q       <= '0;
            last_q    <= 1'b0;
            result_q  <= 1'b0;
            wait_cnt  <= '0;
            addr_q    <= '0;
            collision <= 1'b0;
            busy      <= 1'b0;
            scan_done <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (frame_rise && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_rise) begin
                        state <= LATCH;
                        busy  <= 1'b1;
                    end
                end
                LATCH: begin
                    x_q    <= spriteX;
                    y_q    <= spriteY;
                    s_q    <= spriteS;
                    dir_q  <= decode_key(keycode);
                    o_q    <= -signed'({2'b00, spriteS});
                    last_q <= (spriteS == 10'd0);
                    if (decode_key(keycode) == DIR_NONE) begin
                        result_q <= 1'b0;
                        state    <= DONE;
                    end else begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (probe_oob) begin
                        result_q <= 1'b1;
                        state    <= DONE;
                    end else begin
                        addr_q   <= probe_addr;
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                CHECK: begin
                    if (mem_data) begin
                        result_q <= 1'b1;
                        state    <= DONE;
                    end else if (last_q) begin
                        result_q <= 1'b0;
                        state    <= DONE;
                    end else begin
                        // Clamp the final probe onto the far corner of the edge
                        if (o_q + TILE >= signed'({2'b00, s_q})) begin
                            o_q    <= signed'({2'b00, s_q});
                            last_q <= 1'b1;
                        end else begin
                            o_q <= o_q + TILE;
                        end
                        state <= ISSUE;
                    end
                end
                DONE: begin
                    collision <= result_q;
                    scan_done <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
